dct8_odd_mac: RTL and testbench
===============================

# dct8_odd_mac

Serial multiply-accumulate stage for the odd half of the 8-point DCT-II. It accepts the four odd-part butterfly differences d0..d3 (d_n = x_n − x_(7−n)), one per beat. Each beat drives the shared 18/50/75/89 shift-add multiplier unit, and the block accumulates the signed products into the odd coefficients y1, y3, y5 and y7. It sits between the first butterfly stage and the transpose/output buffer of the 1-D transform.

## Interface
- No parameters. Widths are fixed.
  - Input width: 19 bits signed.
  - Product and accumulator width: 27 bits signed.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a valid beat.
- `in_ready` output 1: the block accepts the beat this cycle.
- `in_data` input 19: signed odd difference d_n, sent in order n = 0,1,2,3.
- `out_valid` output 1: `y1`..`y7` hold a completed frame.
- `out_ready` input 1: downstream consumes the output this cycle.
- `y1`, `y3`, `y5`, `y7` output 27 each: signed odd DCT coefficients.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- A 2-bit beat counter `cnt` (0..3) selects the coefficient column. It increments on each accepted beat and wraps from 3 to 0.
- The multiplier is purely combinational on `in_data` and yields p18, p50, p75, p89. Per-beat signed contributions to (y1, y3, y5, y7):
  - n=0: +89, +75, +50, +18
  - n=1: +75, −18, −89, −50
  - n=2: +50, −89, +18, +75
  - n=3: +18, −50, +75, −89
- Accumulators acc1/3/5/7 are 27-bit signed.
  - Beat 0 loads the accumulators with the contribution; there is no separate clear.
  - Beats 1 and 2 add the contribution.
  - Beat 3 writes acc + contribution directly into the output registers and sets `out_valid`.
- Range: |d| ≤ 2^18, so |y| ≤ 232·2^18 < 2^26. 27-bit two's-complement arithmetic never overflows. No saturation or rounding.
- Output registers hold their value while `out_valid && !out_ready`.
  - On `out_ready` with `out_valid`: `out_valid` clears, unless beat 3 of the next frame is accepted in the same cycle. In that case the registers reload and `out_valid` stays 1.
- `in_ready = !(cnt == 3 && out_valid && !out_ready)`.
  - Beats 0–2 of the next frame are always accepted while an output is pending.
  - Only beat 3 stalls.
- Control states, implicit in `cnt` and `out_valid`:
  - IDLE/ACCUM: `cnt` 0..3, `out_valid` 0.
  - ACCUM+HOLD: `cnt` 0..3, `out_valid` 1.
  - The only stall point is `cnt` = 3 in ACCUM+HOLD with `out_ready` 0.
- `in_valid` low mid-frame: `cnt` and the accumulators hold. There is no timeout.

## Timing
- Reset values (asynchronous, immediate):
  - `cnt` = 0, `out_valid` = 0.
  - acc1..acc7 = 0.
  - `y1`, `y3`, `y5`, `y7` = 0.
  - `in_ready` = 1.
- Reset mid-frame discards the partial frame and any pending output. The first beat after release is d0.
- Latency: `out_valid` rises on the clock edge that accepts beat 3. Outputs are visible in the cycle following that edge.
- Throughput: one frame per 4 cycles with `in_valid` continuously high and `out_ready` continuously high. No bubbles.
- `in_ready` is combinational from `cnt`, `out_valid` and `out_ready`.
- Outputs are registered. There is no combinational path from `in_data` to `y*`.
- The multiplier-plus-adder path must close in one cycle: 19-bit shift-add, then a 27-bit add/sub.

## Test plan
- Unit column 0: frame d = [1,0,0,0] → one `out_valid` pulse with y1 = 89, y3 = 75, y5 = 50, y7 = 18.
- Unit column 1: frame d = [0,1,0,0] → y1 = 75, y3 = −18, y5 = −89, y7 = −50.
- All-ones sum: frame d = [1,1,1,1] → y1 = 232, y3 = −82, y5 = 54, y7 = −46.
- Extreme range: d = [−262144 ×4] → y1 = −60817408 with no overflow. Then 100 random frames checked against a 64-bit reference model.
- Backpressure: hold `out_ready` = 0 and stream two frames.
  - Beats 0–2 of frame 2 are accepted.
  - `in_ready` = 0 at beat 3 while frame 1's outputs stay stable.
  - Raise `out_ready` → frame 1 is consumed and beat 3 is accepted in the same cycle. `out_valid` stays 1 and frame 2's values appear next cycle.
- Reset mid-frame: accept d0, d1 = 1000, 2000, then pulse `rst`.
  - All outputs go to 0 and `out_valid` = 0 immediately.
  - The next frame [1,0,0,0] gives y1 = 89 (no residue).

Source files
------------

// File: rtl/dct8_odd_mac_if.sv
// Odd-half DCT stage bus: differences d0..d3 in, odd coefficients y1/y3/y5/y7 out.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready on the input beat, out_valid/out_ready on the frame result.
interface dct8_odd_mac_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [18:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [26:0] y1;
    logic signed [26:0] y3;
    logic signed [26:0] y5;
    logic signed [26:0] y7;

    // Producer of differences and consumer of coefficients
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, y1, y3, y5, y7
    );

    // The MAC stage itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, y1, y3, y5, y7
    );
endinterface

// File: rtl/dct8_odd_mac.sv
// Serial MAC for the odd half of an 8-point DCT-II: d0..d3 in, one beat per cycle, y1/y3/y5/y7 out.
// Latency: out_valid rises on the edge accepting d3; results are registered, one frame per 4 cycles.
// Backpressure: only d3 stalls, and only while an unconsumed result is held; d0..d2 always flow.
module dct8_odd_mac (
    input  logic               clk,
    input  logic               rst,
    dct8_odd_mac_if.slave      bus
);
    logic [1:0]         cnt_q, cnt_d;
    logic               ov_q, ov_d;
    logic signed [26:0] acc1_q, acc3_q, acc5_q, acc7_q;
    logic signed [26:0] acc1_d, acc3_d, acc5_d, acc7_d;
    logic signed [26:0] y1_q, y3_q, y5_q, y7_q;
    logic signed [26:0] y1_d, y3_d, y5_d, y7_d;

    logic signed [26:0] x;
    logic signed [26:0] p18, p50, p75, p89;
    logic signed [26:0] c1, c3, c5, c7;
    logic signed [26:0] s1, s3, s5, s7;
    logic               accept;

    // Sign-extend once so every shifted partial product lives in the accumulator width.
    assign x   = {{8{bus.in_data[18]}}, bus.in_data};
    assign p18 = (x <<< 4) + (x <<< 1);
    assign p50 = (x <<< 5) + (x <<< 4) + (x <<< 1);
    assign p75 = (x <<< 6) + (x <<< 3) + (x <<< 1) + x;
    assign p89 = (x <<< 6) + (x <<< 4) + (x <<< 3) + x;

    // Beat 3 can only retire into the output registers if the held result leaves this cycle.
    assign bus.in_ready = !((cnt_q == 2'd3) && ov_q && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Pick the signed coefficient column for the current beat index.
    always_comb begin
        c1 = p89;
        c3 = p75;
        c5 = p50;
        c7 = p18;
        case (cnt_q)
            2'd1: begin
                c1 = p75;
                c3 = -p18;
                c5 = -p89;
                c7 = -p50;
            end
            2'd2: begin
                c1 = p50;
                c3 = -p89;
                c5 = p18;
                c7 = p75;
            end
            2'd3: begin
                c1 = p18;
                c3 = -p50;
                c5 = p75;
                c7 = -p89;
            end
            default: ;
        endcase
    end

    // Beat 0 starts from zero instead of the stale accumulator, so no clear cycle is needed.
    assign s1 = ((cnt_q == 2'd0) ? 27'sd0 : acc1_q) + c1;
    assign s3 = ((cnt_q == 2'd0) ? 27'sd0 : acc3_q) + c3;
    assign s5 = ((cnt_q == 2'd0) ? 27'sd0 : acc5_q) + c5;
    assign s7 = ((cnt_q == 2'd0) ? 27'sd0 : acc7_q) + c7;

    // Next state: advance the beat counter, accumulate beats 0..2, retire beat 3 to the outputs.
    always_comb begin
        cnt_d  = cnt_q;
        ov_d   = ov_q;
        acc1_d = acc1_q;
        acc3_d = acc3_q;
        acc5_d = acc5_q;
        acc7_d = acc7_q;
        y1_d   = y1_q;
        y3_d   = y3_q;
        y5_d   = y5_q;
        y7_d   = y7_q;
        if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end
        if (accept) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                y1_d = s1;
                y3_d = s3;
                y5_d = s5;
                y7_d = s7;
                ov_d = 1'b1;
            end else begin
                acc1_d = s1;
                acc3_d = s3;
                acc5_d = s5;
                acc7_d = s7;
            end
        end
    end

    // State registers; reset drops any partial frame and any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            ov_q   <= 1'b0;
            acc1_q <= '0;
            acc3_q <= '0;
            acc5_q <= '0;
            acc7_q <= '0;
            y1_q   <= '0;
            y3_q   <= '0;
            y5_q   <= '0;
            y7_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            acc1_q <= acc1_d;
            acc3_q <= acc3_d;
            acc5_q <= acc5_d;
            acc7_q <= acc7_d;
            y1_q   <= y1_d;
            y3_q   <= y3_d;
            y5_q   <= y5_d;
            y7_q   <= y7_d;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.y1        = y1_q;
    assign bus.y3        = y3_q;
    assign bus.y5        = y5_q;
    assign bus.y7        = y7_q;
endmodule

// File: tb/tb_dct8_odd_mac.sv
// Directed and random frames through the odd-DCT MAC, checked against hand values and a wide model.
// Latency: results are sampled on the falling edge after the edge that accepts d3.
// Backpressure: exercises the d3 stall while a result is held and the same-cycle consume/reload.
module tb_dct8_odd_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dct8_odd_mac_if bus_if ();

    dct8_odd_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Coefficient table: row = beat n, column = y1, y3, y5, y7.
    int coef [4][4] = '{'{89, 75, 50, 18},
                        '{75, -18, -89, -50},
                        '{50, -89, 18, 75},
                        '{18, -50, 75, -89}};

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model(input int k, input int d [4]);
        longint s = 0;
        for (int n = 0; n < 4; n++) s += longint'(d[n]) * longint'(coef[n][k]);
        return s;
    endfunction

    task automatic check_y(input string tag, input longint e [4]);
        check_eq({tag, "_y1"}, bus_if.y1, e[0]);
        check_eq({tag, "_y3"}, bus_if.y3, e[1]);
        check_eq({tag, "_y5"}, bus_if.y5, e[2]);
        check_eq({tag, "_y7"}, bus_if.y7, e[3]);
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is accepted.
    task automatic send_beat(input int d);
        int guard = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d[18:0];
        while (!bus_if.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("beat_rdy_timeout", bus_if.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int d [4], input longint e [4], input int gap);
        bus_if.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send_beat(d[b]);
            if (b < 3) repeat (gap) @(negedge clk);
        end
        check_eq({tag, "_vld"}, bus_if.out_valid, 1);
        check_y(tag, e);
        @(negedge clk);
        check_eq({tag, "_pulse"}, bus_if.out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d [4];
        int prev [4];
        longint e [4];
        bit have;

        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b1;

        // Reset state
        #1;
        check_eq("rst_vld", bus_if.out_valid, 0);
        check_eq("rst_rdy", bus_if.in_ready, 1);
        e = '{0, 0, 0, 0};
        check_y("rst", e);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed frames with hand-computed results
        run_frame("col0", '{1, 0, 0, 0}, '{89, 75, 50, 18}, 0);
        run_frame("col1", '{0, 1, 0, 0}, '{75, -18, -89, -50}, 0);
        run_frame("ones", '{1, 1, 1, 1}, '{232, -82, 54, -46}, 0);
        run_frame("extreme", '{-262144, -262144, -262144, -262144},
                  '{-60817408, 21495808, -14155776, 12058624}, 2);
        run_frame("col3_gaps", '{0, 0, 0, 1}, '{18, -50, 75, -89}, 3);

        // Back-to-back random frames: no bubbles, one out_valid pulse every 4 cycles
        bus_if.out_ready = 1'b1;
        have = 1'b0;
        for (int f = 0; f < 100; f++) begin
            for (int b = 0; b < 4; b++) d[b] = int'($urandom_range(0, 524287)) - 262144;
            for (int b = 0; b < 4; b++) begin
                check_eq("stream_vld", bus_if.out_valid, (b == 0 && have) ? 1 : 0);
                if (b == 0 && have) begin
                    for (int k = 0; k < 4; k++) e[k] = model(k, prev);
                    check_y("stream", e);
                end
                bus_if.in_valid = 1'b1;
                bus_if.in_data  = d[b][18:0];
                check_eq("stream_rdy", bus_if.in_ready, 1);
                @(posedge clk);
                @(negedge clk);
            end
            prev = d;
            have = 1'b1;
        end
        bus_if.in_valid = 1'b0;
        check_eq("stream_last_vld", bus_if.out_valid, 1);
        for (int k = 0; k < 4; k++) e[k] = model(k, prev);
        check_y("stream_last", e);
        @(negedge clk);

        // Backpressure: frame A held, frame B beats 0..2 flow, beat 3 stalls
        bus_if.out_ready = 1'b0;
        send_beat(1); send_beat(0); send_beat(0); send_beat(0);
        check_eq("bp_a_vld", bus_if.out_valid, 1);
        e = '{89, 75, 50, 18};
        check_y("bp_a", e);
        d = '{0, 0, 1, 0};
        for (int b = 0; b < 3; b++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = d[b][18:0];
            check_eq("bp_b_rdy", bus_if.in_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d[3][18:0];
        check_eq("bp_stall_rdy", bus_if.in_ready, 0);
        check_y("bp_hold", e);
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_stall_rdy2", bus_if.in_ready, 0);
        check_eq("bp_hold_vld", bus_if.out_valid, 1);
        check_y("bp_hold2", e);
        bus_if.out_ready = 1'b1;
        #1;
        check_eq("bp_release_rdy", bus_if.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check_eq("bp_b_vld", bus_if.out_valid, 1);
        e = '{50, -89, 18, 75};
        check_y("bp_b", e);
        @(negedge clk);
        check_eq("bp_b_consumed", bus_if.out_valid, 0);

        // Reset mid-frame with a result pending
        bus_if.out_ready = 1'b0;
        send_beat(0); send_beat(0); send_beat(1); send_beat(0);
        check_eq("mid_pending_vld", bus_if.out_valid, 1);
        send_beat(1000);
        send_beat(2000);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_vld", bus_if.out_valid, 0);
        check_eq("mid_rst_rdy", bus_if.in_ready, 1);
        e = '{0, 0, 0, 0};
        check_y("mid_rst", e);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("post_rst", '{1, 0, 0, 0}, '{89, 75, 50, 18}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
